cim_row_array: RTL

Parametrised compute-in-memory row array built from single-bit storage cells. It holds ROWS words of WIDTH bits and supports single-cycle write, read and clear operations. It also performs in-array bit-serial addition (D = A + B, LSB first) through one shared full-adder/carry path. It sits between the convolution controller (command side) and the accumulation datapath, and replaces per-cell wordline driving with a clocked command handshake.

---
 rtl/cim_pkg.sv | 28 ++
 rtl/cim_row_array_if.sv | 31 +++
 rtl/cim_serial_adder.sv | 32 +++
 rtl/cim_row_array.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Shared definitions for the compute-in-memory row array: command opcodes,
// control FSM state encoding and the full-adder bit functions used by the
// shared bit-serial adder.
package cim_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_CLEAR = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ADD_RUN  = 2'd1,
        ST_ADD_DONE = 2'd2
    } state_t;

    // Sum output of a 1-bit full adder.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Carry output of a 1-bit full adder (majority of the three inputs).
    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/cim_row_array_if.sv
// Command/response bundle between the convolution controller (master) and
// the row array (slave).
interface cim_row_array_if #(
    parameter int WIDTH = 8,
    parameter int ROWS  = 16
) ();
    localparam int ADDR_W = $clog2(ROWS);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_d;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;
    logic              rdata_valid;
    logic              done;
    logic              carry_out;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, addr_a, addr_b, addr_d, wdata,
        input  cmd_ready, rdata, rdata_valid, done, carry_out, err
    );

    modport slave (
        input  cmd_valid, cmd_op, addr_a, addr_b, addr_d, wdata,
        output cmd_ready, rdata, rdata_valid, done, carry_out, err
    );
endinterface

// File: rtl/cim_serial_adder.sv
// Shared 1-bit full adder with its carry flop. The carry is cleared
// synchronously when an ADD starts and advances once per enabled bit cycle.
module cim_serial_adder
    import cim_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic en,
    input  logic a_bit,
    input  logic b_bit,
    output logic sum_bit,
    output logic carry_next
);
    logic carry_r;

    assign sum_bit    = fa_sum(a_bit, b_bit, carry_r);
    assign carry_next = fa_carry(a_bit, b_bit, carry_r);

    // Carry state: cleared on start, advanced on each bit step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_r <= 1'b0;
        end else if (start) begin
            carry_r <= 1'b0;
        end else if (en) begin
            carry_r <= carry_next;
        end else begin
            carry_r <= carry_r;
        end
    end
endmodule

// File: rtl/cim_row_array.sv
// Compute-in-memory row array: ROWS x WIDTH storage with single-cycle
// write/read/clear and an in-array bit-serial ADD (D = A + B, LSB first)
// that streams one bit per cycle through a single shared full adder.
module cim_row_array
    import cim_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ROWS  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    cim_row_array_if.slave  bus
);
    localparam int ADDR_W = $clog2(ROWS);
    localparam int K_W    = $clog2(WIDTH);
    localparam logic [K_W-1:0]  K_LAST = K_W'(WIDTH - 1);
    localparam logic [ADDR_W:0] ROWS_L = (ADDR_W + 1)'(ROWS);

    logic [WIDTH-1:0]  mem_r [ROWS];
    state_t            state_r;
    logic              ready_r;
    logic [WIDTH-1:0]  rdata_r;
    logic              rdata_valid_r;
    logic              done_r;
    logic              carry_out_r;
    logic              err_r;
    logic [ADDR_W-1:0] add_a_r;
    logic [ADDR_W-1:0] add_b_r;
    logic [ADDR_W-1:0] add_d_r;
    logic [K_W-1:0]    k_r;

    logic accept_s;
    logic a_ok_s;
    logic b_ok_s;
    logic d_ok_s;
    logic op_bad_s;
    logic cmd_err_s;
    logic wr_s;
    logic rd_s;
    logic clr_s;
    logic add_start_s;
    logic add_step_s;
    logic a_bit_s;
    logic b_bit_s;
    logic sum_bit_s;
    logic carry_next_s;

    // Command decode: acceptance, address range checks and per-op strobes.
    always_comb begin
        accept_s    = 1'b0;
        a_ok_s      = 1'b0;
        b_ok_s      = 1'b0;
        d_ok_s      = 1'b0;
        op_bad_s    = 1'b1;
        cmd_err_s   = 1'b0;
        wr_s        = 1'b0;
        rd_s        = 1'b0;
        clr_s       = 1'b0;
        add_start_s = 1'b0;
        add_step_s  = 1'b0;
        a_bit_s     = 1'b0;
        b_bit_s     = 1'b0;

        accept_s = bus.cmd_valid & ready_r;
        a_ok_s   = ({1'b0, bus.addr_a} < ROWS_L);
        b_ok_s   = ({1'b0, bus.addr_b} < ROWS_L);
        d_ok_s   = ({1'b0, bus.addr_d} < ROWS_L);

        case (bus.cmd_op)
            OP_NOP:                       op_bad_s = 1'b0;
            OP_WRITE, OP_READ, OP_CLEAR:  op_bad_s = ~a_ok_s;
            OP_ADD:                       op_bad_s = ~(a_ok_s & b_ok_s & d_ok_s);
            default:                      op_bad_s = 1'b1;
        endcase

        cmd_err_s   = accept_s & op_bad_s;
        wr_s        = accept_s & ~op_bad_s & (bus.cmd_op == OP_WRITE);
        rd_s        = accept_s & ~op_bad_s & (bus.cmd_op == OP_READ);
        clr_s       = accept_s & ~op_bad_s & (bus.cmd_op == OP_CLEAR);
        add_start_s = accept_s & ~op_bad_s & (bus.cmd_op == OP_ADD);

        // Latched ADD operands are always in range, so these reads are safe.
        add_step_s = (state_r == ST_ADD_RUN);
        a_bit_s    = mem_r[add_a_r][k_r];
        b_bit_s    = mem_r[add_b_r][k_r];
    end

    cim_serial_adder u_adder (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (add_start_s),
        .en         (add_step_s),
        .a_bit      (a_bit_s),
        .b_bit      (b_bit_s),
        .sum_bit    (sum_bit_s),
        .carry_next (carry_next_s)
    );

    // Row storage: whole-row write/clear from commands, single-bit ADD updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_s) begin
            mem_r[bus.addr_a] <= bus.wdata;
        end else if (clr_s) begin
            mem_r[bus.addr_a] <= '0;
        end else if (add_step_s) begin
            mem_r[add_d_r][k_r] <= sum_bit_s;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Control FSM with registered handshake, read data and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            ready_r       <= 1'b1;
            rdata_r       <= '0;
            rdata_valid_r <= 1'b0;
            done_r        <= 1'b0;
            carry_out_r   <= 1'b0;
            err_r         <= 1'b0;
            add_a_r       <= '0;
            add_b_r       <= '0;
            add_d_r       <= '0;
            k_r           <= '0;
        end else begin
            rdata_valid_r <= rd_s;
            err_r         <= cmd_err_s;
            done_r        <= 1'b0;
            if (rd_s) begin
                rdata_r <= mem_r[bus.addr_a];
            end else begin
                rdata_r <= rdata_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (add_start_s) begin
                        state_r <= ST_ADD_RUN;
                        ready_r <= 1'b0;
                        add_a_r <= bus.addr_a;
                        add_b_r <= bus.addr_b;
                        add_d_r <= bus.addr_d;
                        k_r     <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                    end
                end
                ST_ADD_RUN: begin
                    if (k_r == K_LAST) begin
                        state_r     <= ST_ADD_DONE;
                        carry_out_r <= carry_next_s;
                        done_r      <= 1'b1;
                    end else begin
                        k_r <= k_r + K_W'(1);
                    end
                end
                ST_ADD_DONE: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = ready_r;
    assign bus.rdata       = rdata_r;
    assign bus.rdata_valid = rdata_valid_r;
    assign bus.done        = done_r;
    assign bus.carry_out   = carry_out_r;
    assign bus.err         = err_r;
endmodule
